// File: rtl/id_ex_stage.sv
// ID/EX pipeline register, operand select and ALU op decode for the RV32I core.
// Define ID_EX_FORWARD_EN for forwarding muxes; otherwise any pending RAW stalls.
module id_ex_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            flush,
  input  logic            id_valid,
  input  logic [XLEN-1:0] id_pc,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic [4:0]      id_rs1_addr,
  input  logic [4:0]      id_rs2_addr,
  input  logic [4:0]      id_rd_addr,
  input  logic [2:0]      id_fun3,
  input  logic            id_fun7_5,
  input  logic [1:0]      id_op_type,
  input  logic [1:0]      id_a_sel,
  input  logic            id_b_sel,
  input  logic            id_reg_write,
  input  logic            id_mem_read,
  input  logic            id_mem_write,
  input  logic [4:0]      exm_rd_addr,
  input  logic            exm_reg_write,
  input  logic [XLEN-1:0] exm_result,
  input  logic [4:0]      mwb_rd_addr,
  input  logic            mwb_reg_write,
  input  logic [XLEN-1:0] mwb_data,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [3:0]      alu_operation,
  output logic [XLEN-1:0] ex_store_data,
  output logic            ex_valid,
  output logic            ex_reg_write,
  output logic            ex_mem_read,
  output logic            ex_mem_write,
  output logic [4:0]      ex_rd_addr,
  output logic [XLEN-1:0] ex_pc,
  output logic            hazard_stall
);

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1_addr;
    logic [4:0]      rs2_addr;
    logic [4:0]      rd_addr;
    logic [2:0]      fun3;
    logic            fun7_5;
    logic [1:0]      op_type;
    logic [1:0]      a_sel;
    logic            b_sel;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
  } id_ex_t;

  id_ex_t          r_q;
  id_ex_t          w_d;
  logic [XLEN-1:0] w_rs1;
  logic [XLEN-1:0] w_rs2;
  logic [3:0]      w_alu_op;
  logic            w_load_use;
  logic            w_raw;

  always_comb begin
    w_d          = '0;
    w_d.valid    = id_valid;
    w_d.pc       = id_pc;
    w_d.rs1_data = id_rs1_data;
    w_d.rs2_data = id_rs2_data;
    w_d.imm      = id_imm;
    w_d.rs1_addr = id_rs1_addr;
    w_d.rs2_addr = id_rs2_addr;
    w_d.rd_addr  = id_rd_addr;
    w_d.fun3     = id_fun3;
    w_d.fun7_5   = id_fun7_5;
    w_d.op_type  = id_op_type;
    w_d.a_sel    = id_a_sel;
    w_d.b_sel    = id_b_sel;
    w_d.reg_write = id_reg_write;
    w_d.mem_read  = id_mem_read;
    w_d.mem_write = id_mem_write;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_q <= '0;
    end else if (flush) begin
      r_q <= '0;
    end else if (!stall) begin
      r_q <= w_d;
    end
  end

`ifdef ID_EX_FORWARD_EN
  logic w_exm_rs1, w_exm_rs2, w_mwb_rs1, w_mwb_rs2;

  assign w_exm_rs1 = exm_reg_write && exm_rd_addr != 5'd0
                     && exm_rd_addr == r_q.rs1_addr;
  assign w_exm_rs2 = exm_reg_write && exm_rd_addr != 5'd0
                     && exm_rd_addr == r_q.rs2_addr;
  assign w_mwb_rs1 = mwb_reg_write && mwb_rd_addr != 5'd0
                     && mwb_rd_addr == r_q.rs1_addr;
  assign w_mwb_rs2 = mwb_reg_write && mwb_rd_addr != 5'd0
                     && mwb_rd_addr == r_q.rs2_addr;

  // EX/MEM is the younger result, so it shadows MEM/WB
  assign w_rs1 = w_exm_rs1 ? exm_result :
                 w_mwb_rs1 ? mwb_data : r_q.rs1_data;
  assign w_rs2 = w_exm_rs2 ? exm_result :
                 w_mwb_rs2 ? mwb_data : r_q.rs2_data;
  assign w_raw = 1'b0;
`else
  logic w_raw1, w_raw2;
  logic w_unused;

  assign w_rs1 = r_q.rs1_data;
  assign w_rs2 = r_q.rs2_data;

  assign w_raw1 = id_rs1_addr != 5'd0 && (
    (r_q.reg_write && r_q.valid && r_q.rd_addr == id_rs1_addr) ||
    (exm_reg_write && exm_rd_addr == id_rs1_addr) ||
    (mwb_reg_write && mwb_rd_addr == id_rs1_addr));
  assign w_raw2 = id_rs2_addr != 5'd0 && (
    (r_q.reg_write && r_q.valid && r_q.rd_addr == id_rs2_addr) ||
    (exm_reg_write && exm_rd_addr == id_rs2_addr) ||
    (mwb_reg_write && mwb_rd_addr == id_rs2_addr));
  assign w_raw = w_raw1 || w_raw2;

  assign w_unused = ^{exm_result, mwb_data, r_q.rs1_addr, r_q.rs2_addr};
`endif

  assign w_load_use = r_q.valid && r_q.mem_read && r_q.rd_addr != 5'd0
                      && id_valid
                      && (r_q.rd_addr == id_rs1_addr
                          || r_q.rd_addr == id_rs2_addr);

  // I-type keeps fun7_5 only for srai, so addi with imm[10]=1 stays add
  always_comb begin
    w_alu_op = 4'b0000;
    unique case (r_q.op_type)
      2'b00: w_alu_op = 4'b0000;
      2'b01: w_alu_op = {r_q.fun7_5, r_q.fun3};
      2'b10: w_alu_op = {(r_q.fun3 == 3'b101) & r_q.fun7_5, r_q.fun3};
      default: begin
        unique case (1'b1)
          r_q.fun3[2:1] == 2'b11: w_alu_op = 4'b0011;
          r_q.fun3[2:1] == 2'b10: w_alu_op = 4'b0010;
          default:                w_alu_op = 4'b1000;
        endcase
      end
    endcase
  end

  always_comb begin
    alu_a = '0;
    unique case (r_q.a_sel)
      2'b00:   alu_a = w_rs1;
      2'b01:   alu_a = r_q.pc;
      default: alu_a = '0;
    endcase
  end

  assign alu_b         = r_q.b_sel ? r_q.imm : w_rs2;
  assign alu_operation = w_alu_op;
  assign ex_store_data = w_rs2;
  assign ex_valid      = r_q.valid;
  assign ex_reg_write  = r_q.reg_write;
  assign ex_mem_read   = r_q.mem_read;
  assign ex_mem_write  = r_q.mem_write;
  assign ex_rd_addr    = r_q.rd_addr;
  assign ex_pc         = r_q.pc;
  assign hazard_stall  = w_load_use || w_raw;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed + randomized bench for id_ex_stage against a behavioural model.
// Works for both builds: with and without ID_EX_FORWARD_EN.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst_n, stall, flush;
  logic        id_valid;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr;
  logic [2:0]  id_fun3;
  logic        id_fun7_5;
  logic [1:0]  id_op_type, id_a_sel;
  logic        id_b_sel, id_reg_write, id_mem_read, id_mem_write;
  logic [4:0]  exm_rd_addr, mwb_rd_addr;
  logic        exm_reg_write, mwb_reg_write;
  logic [31:0] exm_result, mwb_data;
  logic [31:0] alu_a, alu_b, ex_store_data, ex_pc;
  logic [3:0]  alu_operation;
  logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write;
  logic [4:0]  ex_rd_addr;
  logic        hazard_stall;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .id_valid(id_valid), .id_pc(id_pc),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
    .id_imm(id_imm), .id_rs1_addr(id_rs1_addr),
    .id_rs2_addr(id_rs2_addr), .id_rd_addr(id_rd_addr),
    .id_fun3(id_fun3), .id_fun7_5(id_fun7_5),
    .id_op_type(id_op_type), .id_a_sel(id_a_sel),
    .id_b_sel(id_b_sel), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .exm_rd_addr(exm_rd_addr), .exm_reg_write(exm_reg_write),
    .exm_result(exm_result), .mwb_rd_addr(mwb_rd_addr),
    .mwb_reg_write(mwb_reg_write), .mwb_data(mwb_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_operation(alu_operation),
    .ex_store_data(ex_store_data), .ex_valid(ex_valid),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_rd_addr(ex_rd_addr),
    .ex_pc(ex_pc), .hazard_stall(hazard_stall)
  );

  // Model of the instruction currently held in EX
  typedef struct {
    bit        v;
    bit [31:0] pc, d1, d2, imm;
    bit [4:0]  a1, a2, rd;
    int        f3, f75, op, asel;
    bit        bsel, rw, mr, mw;
  } ex_t;

  ex_t m;

  function automatic bit [31:0] fwd(input bit [4:0] a,
                                    input bit [31:0] d);
`ifdef ID_EX_FORWARD_EN
    if (exm_reg_write && exm_rd_addr != 0 && exm_rd_addr == a)
      return exm_result;
    if (mwb_reg_write && mwb_rd_addr != 0 && mwb_rd_addr == a)
      return mwb_data;
`endif
    return d;
  endfunction

  function automatic bit [3:0] exp_op();
    int r;
    case (m.op)
      0: r = 0;
      1: r = m.f75 * 8 + m.f3;
      2: r = (m.f3 == 5) ? m.f75 * 8 + 5 : m.f3;
      default: r = (m.f3 >= 6) ? 3 : (m.f3 >= 4) ? 2 : 8;
    endcase
    return 4'(r);
  endfunction

  function automatic bit dep(input bit [4:0] a);
    if (a == 0) return 0;
    return (m.rw && m.v && m.rd == a)
        || (exm_reg_write && exm_rd_addr == a)
        || (mwb_reg_write && mwb_rd_addr == a);
  endfunction

  function automatic bit exp_haz();
    bit h;
    h = m.v && m.mr && m.rd != 0 && id_valid
        && (m.rd == id_rs1_addr || m.rd == id_rs2_addr);
`ifndef ID_EX_FORWARD_EN
    h = h || dep(id_rs1_addr) || dep(id_rs2_addr);
`endif
    return h;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    bit [31:0] ea;
    ea = (m.asel == 0) ? fwd(m.a1, m.d1) : (m.asel == 1) ? m.pc : 0;
    chk({tag, ".alu_a"}, alu_a, ea);
    chk({tag, ".alu_b"}, alu_b, m.bsel ? m.imm : fwd(m.a2, m.d2));
    chk({tag, ".alu_op"}, 32'(alu_operation), 32'(exp_op()));
    chk({tag, ".store"}, ex_store_data, fwd(m.a2, m.d2));
    chk({tag, ".valid"}, 32'(ex_valid), 32'(m.v));
    chk({tag, ".rw"}, 32'(ex_reg_write), 32'(m.rw));
    chk({tag, ".mr"}, 32'(ex_mem_read), 32'(m.mr));
    chk({tag, ".mw"}, 32'(ex_mem_write), 32'(m.mw));
    chk({tag, ".rd"}, 32'(ex_rd_addr), 32'(m.rd));
    chk({tag, ".pc"}, ex_pc, m.pc);
    chk({tag, ".haz"}, 32'(hazard_stall), 32'(exp_haz()));
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst_n || flush) begin
      m = '{default: 0};
    end else if (!stall) begin
      m.v = id_valid;  m.pc = id_pc;
      m.d1 = id_rs1_data;  m.d2 = id_rs2_data;  m.imm = id_imm;
      m.a1 = id_rs1_addr;  m.a2 = id_rs2_addr;  m.rd = id_rd_addr;
      m.f3 = int'(id_fun3);  m.f75 = int'(id_fun7_5);
      m.op = int'(id_op_type);  m.asel = int'(id_a_sel);
      m.bsel = id_b_sel;  m.rw = id_reg_write;
      m.mr = id_mem_read;  m.mw = id_mem_write;
    end
    @(negedge clk);
  endtask

  task automatic rand_id();
    id_valid    = 1'($urandom);
    id_pc       = $urandom & 32'hFFFF_FFFC;
    id_rs1_addr = 5'($urandom_range(0, 7));
    id_rs2_addr = 5'($urandom_range(0, 7));
    id_rs1_data = (id_rs1_addr == 0) ? 32'h0 : $urandom;
    id_rs2_data = (id_rs2_addr == 0) ? 32'h0 : $urandom;
    id_imm      = $urandom;
    id_rd_addr  = 5'($urandom_range(0, 7));
    id_fun3     = 3'($urandom);
    id_fun7_5   = 1'($urandom);
    id_op_type  = 2'($urandom);
    id_a_sel    = 2'($urandom);
    id_b_sel    = 1'($urandom);
    id_reg_write = 1'($urandom);
    id_mem_read  = 1'($urandom);
    id_mem_write = 1'($urandom);
  endtask

  task automatic quiet_fwd();
    exm_rd_addr = 0;  exm_reg_write = 0;  exm_result = 0;
    mwb_rd_addr = 0;  mwb_reg_write = 0;  mwb_data = 0;
  endtask

  initial begin
    m = '{default: 0};
    stall = 0;  flush = 0;  rst_n = 0;
    quiet_fwd();
    rand_id();
    id_valid = 1;  id_pc = 32'h40;  id_rd_addr = 5'd9;
    id_reg_write = 1;  id_fun3 = 3'b101;  id_fun7_5 = 1;
    tick();
    tick();
    #1 check_all("reset");
    chk("reset.op", 32'(alu_operation), 32'h0);
    chk("reset.valid", 32'(ex_valid), 32'h0);
    rst_n = 1;

    // addi with fun7_5 set must stay add
    rand_id();
    id_op_type = 2'b10;  id_fun3 = 3'b000;  id_fun7_5 = 1;
    tick();
    #1 check_all("addi");
    chk("addi.op", 32'(alu_operation), 32'h0);

    rand_id();
    id_op_type = 2'b10;  id_fun3 = 3'b101;  id_fun7_5 = 1;
    tick();
    #1 check_all("srai");
    chk("srai.op", 32'(alu_operation), 32'hD);

    rand_id();
    id_op_type = 2'b11;  id_fun3 = 3'b110;
    tick();
    #1 check_all("bltu");
    chk("bltu.op", 32'(alu_operation), 32'h3);

    rand_id();
    id_op_type = 2'b01;  id_fun3 = 3'b000;  id_fun7_5 = 1;
    tick();
    #1 check_all("sub");
    chk("sub.op", 32'(alu_operation), 32'h8);

    // forwarding priority on rs1
    rand_id();
    id_valid = 0;  id_a_sel = 2'b00;
    id_rs1_addr = 5'd5;  id_rs1_data = 32'h11;
    tick();
    exm_rd_addr = 5'd5;  exm_reg_write = 1;  exm_result = 32'hAA;
    mwb_rd_addr = 5'd5;  mwb_reg_write = 1;  mwb_data = 32'hBB;
    #1 check_all("fwd_exm");
`ifdef ID_EX_FORWARD_EN
    chk("fwd_exm.a", alu_a, 32'hAA);
`else
    chk("fwd_exm.a", alu_a, 32'h11);
`endif
    exm_reg_write = 0;
    #1 check_all("fwd_mwb");
`ifdef ID_EX_FORWARD_EN
    chk("fwd_mwb.a", alu_a, 32'hBB);
`else
    chk("fwd_mwb.a", alu_a, 32'h11);
`endif
    exm_reg_write = 1;  exm_rd_addr = 0;  mwb_rd_addr = 0;
    #1 check_all("fwd_x0");
    chk("fwd_x0.a", alu_a, 32'h11);
    quiet_fwd();

    // load-use on rs2
    rand_id();
    id_valid = 1;  id_mem_read = 1;  id_reg_write = 1;
    id_rd_addr = 5'd7;
    tick();
    rand_id();
    id_valid = 1;  id_rs1_addr = 5'd1;  id_rs1_data = 32'h1;
    id_rs2_addr = 5'd7;  id_rs2_data = 32'h77;
    #1 check_all("lduse");
    chk("lduse.haz", 32'(hazard_stall), 32'h1);
    flush = 1;  stall = 1;
    tick();
    flush = 0;  stall = 0;
    #1 check_all("bubble");
    chk("bubble.valid", 32'(ex_valid), 32'h0);
    chk("bubble.rw", 32'(ex_reg_write), 32'h0);

    // stall holds for three cycles
    rand_id();
    id_valid = 1;  id_pc = 32'h100;
    tick();
    for (int i = 0; i < 3; i++) begin
      rand_id();
      stall = 1;
      tick();
      #1 check_all("stall");
      chk("stall.pc", ex_pc, 32'h100);
    end
    flush = 1;
    tick();
    stall = 0;  flush = 0;
    #1 check_all("stflush");
    chk("stflush.pc", ex_pc, 32'h0);

    // RAW on an EX/MEM producer
    rand_id();
    id_valid = 1;  id_mem_read = 0;  id_reg_write = 0;
    id_a_sel = 2'b00;  id_rs1_addr = 5'd3;  id_rs1_data = 32'h33;
    tick();
    id_valid = 1;  id_rs1_addr = 5'd3;  id_rs2_addr = 5'd0;
    exm_rd_addr = 5'd3;  exm_reg_write = 1;  exm_result = 32'hEE;
    #1 check_all("raw");
`ifdef ID_EX_FORWARD_EN
    chk("raw.haz", 32'(hazard_stall), 32'h0);
    chk("raw.a", alu_a, 32'hEE);
`else
    chk("raw.haz", 32'(hazard_stall), 32'h1);
    chk("raw.a", alu_a, 32'h33);
`endif
    quiet_fwd();

    for (int i = 0; i < 400; i++) begin
      rand_id();
      exm_rd_addr = 5'($urandom_range(0, 7));
      exm_reg_write = 1'($urandom);
      exm_result = $urandom;
      mwb_rd_addr = 5'($urandom_range(0, 7));
      mwb_reg_write = 1'($urandom);
      mwb_data = $urandom;
      stall = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 5) == 0);
      rst_n = ($urandom_range(0, 30) != 0);
      #1 check_all("rnd");
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline register and operand-select stage of the pipelined RV32I core. It captures decoded fields from ID on each enabled clock edge and resolves forwarded operands. It produces the ALU's `A`, `B` and 4-bit `ALU_operation` (encoded as `{Fun7[5], Fun3}`), and raises the load-use hazard stall back toward IF/ID.

## Interface
Parameters:
- `XLEN`, 32, datapath width; only 32 is supported.

Ports:
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: synchronous, active-low reset. One clock; reset is synchronous and active-low.
- `stall` in 1: hold all registered fields.
- `flush` in 1: replace the captured instruction with a bubble.
- `id_valid` in 1: ID holds a real instruction.
- `id_pc` in 32: PC of the ID instruction.
- `id_rs1_data`, `id_rs2_data` in 32 each: register file read data.
- `id_imm` in 32: sign-extended immediate.
- `id_rs1_addr`, `id_rs2_addr`, `id_rd_addr` in 5 each: register specifiers.
- `id_fun3` in 3, `id_fun7_5` in 1: function fields.
- `id_op_type` in 2: 00 add-forced, 01 R-type, 10 I-type ALU, 11 branch compare.
- `id_a_sel` in 2: 00 rs1, 01 pc, 10 zero, 11 reserved (treated as zero).
- `id_b_sel` in 1: 0 rs2, 1 imm.
- `id_reg_write`, `id_mem_read`, `id_mem_write` in 1 each: control bits.
- `exm_rd_addr` in 5, `exm_reg_write` in 1, `exm_result` in 32: EX/MEM forwarding source.
- `mwb_rd_addr` in 5, `mwb_reg_write` in 1, `mwb_data` in 32: MEM/WB forwarding source.
- `alu_a`, `alu_b` out 32: ALU operands.
- `alu_operation` out 4: ALU op code.
- `ex_store_data` out 32: forwarded rs2 value.
- `ex_valid`, `ex_reg_write`, `ex_mem_read`, `ex_mem_write` out 1 each.
- `ex_rd_addr` out 5, `ex_pc` out 32.
- `hazard_stall` out 1: ID must hold and this stage must receive `flush`.

## Operation
- Register update on each edge, in priority order:
  1. `!rst_n`: all fields to 0.
  2. `flush`: all fields to 0, so `ex_valid`, `ex_reg_write` and `ex_mem_*` are 0. `flush` wins over `stall`.
  3. `stall`: hold.
  4. Otherwise: capture all `id_*` fields.
- Forwarding (per source rs1/rs2, combinational from registered address):
  - EX/MEM hit: `exm_reg_write && exm_rd_addr != 0 && exm_rd_addr == rsX`.
  - Otherwise MEM/WB hit under the same rule.
  - Otherwise the registered read data.
  - EX/MEM beats MEM/WB. x0 always reads 0.
- Operand A by `a_sel`: forwarded rs1 / pc / 0. Operand B by `b_sel`: forwarded rs2 / imm. `ex_store_data` is always forwarded rs2.
- `alu_operation` by `op_type`:
  - 00 → 0000.
  - 01 → `{fun7_5, fun3}`.
  - 10 → `{(fun3==101) ? fun7_5 : 0, fun3}`. This prevents `addi` with imm[10]=1 from decoding as sub.
  - 11 → 0011 for fun3 110/111, 0010 for 100/101, else 1000.
- `hazard_stall` is 1 when all of the following hold:
  - `ex_valid && ex_mem_read && ex_rd_addr != 0`;
  - `id_valid`;
  - `ex_rd_addr` equals `id_rs1_addr`, or equals `id_rs2_addr`.
- Reset values: every output is 0. `alu_operation` is 0000 and `hazard_stall` is 0.

## Timing
- ID → EX fields: 1-cycle latency.
- `alu_a`, `alu_b`, `alu_operation`, `ex_store_data` are combinational from registered state and same-cycle forwarding inputs. There is no added register before the ALU.
- `hazard_stall` is combinational within the same cycle. The hazard controller must drive `stall` on IF/ID and `flush` here in that cycle, giving exactly one bubble per load-use.
- `flush` and `stall` both high: bubble inserted.
- Reset asserted mid-stall: fields clear on that edge regardless of `stall`/`flush`.
- Forwarding reacts to `exm_*`/`mwb_*` changes in the same cycle while held under `stall`.

## Configuration
- `ID_EX_FORWARD_EN` defined:
  - Forwarding muxes as above.
  - `hazard_stall` covers load-use only.
- Not defined:
  - No forwarding paths; operands come straight from registered read data.
  - `hazard_stall` also asserts when nonzero `id_rs1_addr`/`id_rs2_addr` matches any of: `ex_rd_addr` with `ex_reg_write && ex_valid`; `exm_rd_addr` with `exm_reg_write`; `mwb_rd_addr` with `mwb_reg_write`.

## Test plan
- Reset: hold `rst_n`=0 with nonzero `id_*` inputs → after the edge all outputs are 0 and `alu_operation`=0000.
- Op decode:
  - `op_type`=10, fun3=000, fun7_5=1 → 0000.
  - fun3=101, fun7_5=1 → 1101.
  - `op_type`=11, fun3=110 → 0011.
  - `op_type`=01, fun3=000, fun7_5=1 → 1000.
- Forward priority: registered rs1=5 with read data 0x11, `exm` rd=5 result 0xAA, `mwb` rd=5 data 0xBB → `alu_a`=0xAA. Drop `exm_reg_write` → 0xBB. Set rd=0 on both sources → 0x11.
- Load-use: EX holds a valid load to x7 and ID reads rs2=x7 → `hazard_stall`=1 the same cycle. Apply `flush` → next cycle `ex_valid`=0 and `ex_reg_write`=0.
- Stall/flush interplay:
  - `stall`=1 for 3 cycles → outputs held constant.
  - `stall`=1 with `flush`=1 → bubble on the next edge.
- Macro off: EX/MEM writes x3 and ID reads x3 → `hazard_stall`=1 and `alu_a` equals the registered read data, not `exm_result`.
